// File: rtl/mlp_param_loader_if.sv
// Serial parameter stream handshake for mlp_param_loader.
// The master drives valid and data. The slave drives ready.
interface mlp_param_loader_if #(
  parameter int W = 8
);
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] in_data;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );
endinterface

// File: rtl/mlp_param_loader.sv
// Unpacks a serial word stream into the MLP x/w/b arrays, then pulses start flags.
// MLP_LOADER_CHECKSUM_EN adds a trailing modulo-sum check word before the pulse.
module mlp_param_loader #(
  parameter int M  = 3,
  parameter int N  = 3,
  parameter int QM = 3,
  parameter int QN = 5
) (
  input  logic clk,
  input  logic nrst,
  input  logic start,
  mlp_param_loader_if.slave stream,
  output logic signed [N-1:0][QM+QN-1:0] x,
  output logic signed [M-2:0][N-1:0][N-1:0][QM+QN-1:0] w,
  output logic signed [M-2:0][N-1:0][QM+QN-1:0] b,
  output logic init,
  output logic initial_flag,
  output logic weight_flag,
  output logic busy,
  output logic err
);

  localparam int W  = QM + QN;
  localparam int JW = (N > 1) ? $clog2(N) : 1;
  localparam int LW = (M > 2) ? $clog2(M - 1) : 1;
  localparam int SW = $clog2(N + 1);

`ifdef MLP_LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CHECK,
    FIRE
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FIRE
  } state_t;
`endif

  state_t              state;
  logic                layer_ph;
  logic [LW-1:0]       l;
  logic [JW-1:0]       j;
  logic [SW-1:0]       s;
  logic                rdy;
  logic                acc;
  logic                j_last;
  logic                s_last;
  logic                l_last;
  logic [JW-1:0]       wi;
  logic signed [W-1:0] d;

  assign d      = stream.in_data;
  assign acc    = stream.in_valid && rdy;
  assign stream.in_ready = rdy;
  assign j_last = (j == JW'(N - 1));
  assign s_last = (s == SW'(N));
  assign l_last = (l == LW'(M - 2));
  // slot 0 is the bias, slots 1..N map to weights 0..N-1
  assign wi     = JW'(s - SW'(1));

`ifdef MLP_LOADER_CHECKSUM_EN
  logic [W-1:0] sum;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state        <= IDLE;
      layer_ph     <= 1'b0;
      l            <= '0;
      j            <= '0;
      s            <= '0;
      rdy          <= 1'b0;
      busy         <= 1'b0;
      init         <= 1'b0;
      initial_flag <= 1'b0;
      weight_flag  <= 1'b0;
      x            <= '0;
      w            <= '0;
      b            <= '0;
`ifdef MLP_LOADER_CHECKSUM_EN
      err          <= 1'b0;
      sum          <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state    <= LOAD;
            rdy      <= 1'b1;
            busy     <= 1'b1;
            layer_ph <= 1'b0;
            l        <= '0;
            j        <= '0;
            s        <= '0;
`ifdef MLP_LOADER_CHECKSUM_EN
            err      <= 1'b0;
            sum      <= '0;
`endif
          end
        end
        LOAD: begin
          if (acc) begin
`ifdef MLP_LOADER_CHECKSUM_EN
            sum <= sum + W'(d);
`endif
            if (!layer_ph) begin
              x[j] <= d;
              if (j_last) begin
                j        <= '0;
                layer_ph <= 1'b1;
              end else begin
                j <= j + JW'(1);
              end
            end else begin
              if (s == '0) begin
                b[l][j] <= d;
              end else begin
                w[l][j][wi] <= d;
              end
              if (s_last) begin
                s <= '0;
                if (j_last) begin
                  j <= '0;
                  l <= l_last ? '0 : l + LW'(1);
                end else begin
                  j <= j + JW'(1);
                end
              end else begin
                s <= s + SW'(1);
              end
              if (s_last && j_last && l_last) begin
`ifdef MLP_LOADER_CHECKSUM_EN
                state <= CHECK;
`else
                state        <= FIRE;
                rdy          <= 1'b0;
                busy         <= 1'b0;
                init         <= 1'b1;
                initial_flag <= 1'b1;
                weight_flag  <= 1'b1;
`endif
              end
            end
          end
        end
`ifdef MLP_LOADER_CHECKSUM_EN
        CHECK: begin
          if (acc) begin
            rdy  <= 1'b0;
            busy <= 1'b0;
            if (W'(d) == sum) begin
              state        <= FIRE;
              init         <= 1'b1;
              initial_flag <= 1'b1;
              weight_flag  <= 1'b1;
            end else begin
              state <= IDLE;
              err   <= 1'b1;
            end
          end
        end
`endif
        FIRE: begin
          state        <= IDLE;
          init         <= 1'b0;
          initial_flag <= 1'b0;
          weight_flag  <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mlp_param_loader.sv
// Randomized self-checking bench for mlp_param_loader.
// Reference arrays are filled from the stream order by index arithmetic.
module tb_mlp_param_loader;

  localparam int M  = 3;
  localparam int N  = 3;
  localparam int QM = 3;
  localparam int QN = 5;
  localparam int W  = QM + QN;
  localparam int T  = N + (M - 1) * N * (N + 1);
`ifdef MLP_LOADER_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif
  localparam int TT = T + CS;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic start = 1'b0;
  logic signed [N-1:0][W-1:0] x;
  logic signed [M-2:0][N-1:0][N-1:0][W-1:0] w;
  logic signed [M-2:0][N-1:0][W-1:0] b;
  logic init, initial_flag, weight_flag, busy, err;

  mlp_param_loader_if #(.W(W)) s_if ();

  mlp_param_loader #(.M(M), .N(N), .QM(QM), .QN(QN)) dut (
    .clk(clk),
    .nrst(nrst),
    .start(start),
    .stream(s_if.slave),
    .x(x),
    .w(w),
    .b(b),
    .init(init),
    .initial_flag(initial_flag),
    .weight_flag(weight_flag),
    .busy(busy),
    .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc = -1;
  int pulses = 0;
  int pulse_cyc = -1;
  int rdy_cnt = 0;
  int flag_skew = 0;

  logic [7:0] rx [N];
  logic [7:0] rb [M-1][N];
  logic [7:0] rw [M-1][N][N];
  logic [7:0] sq [$];

  always @(posedge clk) begin
    if (s_if.in_valid && s_if.in_ready) last_acc = cyc;
    cyc++;
  end

  always @(negedge clk) begin
    if (s_if.in_ready) rdy_cnt++;
    if (init) begin
      pulses++;
      pulse_cyc = cyc;
    end
    if (init !== initial_flag || init !== weight_flag) flag_skew++;
  end

  function automatic void clear_model();
    for (int i = 0; i < N; i++) rx[i] = '0;
    for (int l = 0; l < M - 1; l++)
      for (int j = 0; j < N; j++) begin
        rb[l][j] = '0;
        for (int i = 0; i < N; i++) rw[l][j][i] = '0;
      end
  endfunction

  function automatic void apply(input int k, input logic [7:0] d);
    int r, l, j, s;
    if (k < N) begin
      rx[k] = d;
    end else begin
      r = k - N;
      l = r / (N * (N + 1));
      r = r % (N * (N + 1));
      j = r / (N + 1);
      s = r % (N + 1);
      if (s == 0) rb[l][j] = d;
      else rw[l][j][s-1] = d;
    end
  endfunction

  function automatic void build(input int kind, input int napply);
    logic [7:0] d;
    logic [7:0] sum;
    sum = '0;
    sq.delete();
    for (int k = 0; k < T; k++) begin
      if (kind == 0) d = 8'h10;
      else if (kind == 1) d = 8'(k);
      else d = 8'($urandom);
      sq.push_back(d);
      sum = sum + d;
      if (k < napply) apply(k, d);
    end
    if (CS != 0) sq.push_back(sum);
  endfunction

  function automatic int count_diff();
    int n = 0;
    for (int i = 0; i < N; i++) if (x[i] !== rx[i]) n++;
    for (int l = 0; l < M - 1; l++)
      for (int j = 0; j < N; j++) begin
        if (b[l][j] !== rb[l][j]) n++;
        for (int i = 0; i < N; i++)
          if (w[l][j][i] !== rw[l][j][i]) n++;
      end
    return n;
  endfunction

  task automatic clr_mon();
    pulses = 0;
    pulse_cyc = -1;
    last_acc = -1;
    rdy_cnt = 0;
    flag_skew = 0;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // mode 0: back-to-back, 1: valid toggles, 2: random valid
  task automatic send(input int first, input int cnt, input int mode);
    int i = 0;
    int budget = 0;
    bit v;
    bit tog = 1'b1;
    while (i < cnt) begin
      @(negedge clk);
      if (mode == 0) v = 1'b1;
      else if (mode == 1) v = tog;
      else v = 1'($urandom_range(0, 1));
      tog = ~tog;
      s_if.in_valid = v;
      s_if.in_data = v ? sq[first+i] : 8'($urandom);
      if (v && s_if.in_ready) i++;
      budget++;
      if (budget > cnt * 8 + 20) begin
        checks++;
        errors++;
        $display("FAIL send_timeout accepted %0d required %0d", i, cnt);
        break;
      end
    end
    @(negedge clk);
    s_if.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    s_if.in_valid = 1'b0;
    s_if.in_data = '0;
    clear_model();
    #20;
    checks++;
    if (s_if.in_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl ready %b busy %b required 0 0", s_if.in_ready, busy);
    end
    checks++;
    if ({init, initial_flag, weight_flag, err} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags got %b required 0000", {init, initial_flag, weight_flag, err});
    end
    checks++;
    if (count_diff() !== 0) begin
      errors++;
      $display("FAIL reset_arrays diffs %0d required 0", count_diff());
    end
    @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic test_defaults();
    clr_mon();
    build(0, T);
    do_start();
    send(0, TT, 0);
    repeat (3) @(negedge clk);
    checks++;
    if (rdy_cnt !== TT) begin
      errors++;
      $display("FAIL dflt_ready_cycles got %0d required %0d", rdy_cnt, TT);
    end
    checks++;
    if (pulses !== 1 || pulse_cyc !== last_acc + 1) begin
      errors++;
      $display("FAIL dflt_pulse got %0d at %0d required 1 at %0d", pulses, pulse_cyc, last_acc + 1);
    end
    checks++;
    if (flag_skew !== 0) begin
      errors++;
      $display("FAIL dflt_flag_skew got %0d required 0", flag_skew);
    end
    checks++;
    if (count_diff() !== 0) begin
      errors++;
      $display("FAIL dflt_arrays diffs %0d required 0", count_diff());
    end
    checks++;
    if ({busy, s_if.in_ready, err} !== 3'b0) begin
      errors++;
      $display("FAIL dflt_idle got %b required 000", {busy, s_if.in_ready, err});
    end
  endtask

  task automatic test_index_map();
    logic [7:0] act [5];
    int exp_v [5] = '{2, 3, 14, 15, 26};
    clr_mon();
    build(1, T);
    do_start();
    send(0, TT, 0);
    repeat (3) @(negedge clk);
    act[0] = x[2];
    act[1] = b[0][0];
    act[2] = w[0][2][2];
    act[3] = b[1][0];
    act[4] = w[1][2][2];
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (act[i] !== 8'(exp_v[i])) begin
        errors++;
        $display("FAIL idx_map_%0d got %0d required %0d", i, act[i], exp_v[i]);
      end
    end
    checks++;
    if (count_diff() !== 0 || pulses !== 1) begin
      errors++;
      $display("FAIL idx_all diffs %0d pulses %0d required 0 1", count_diff(), pulses);
    end
  endtask

  task automatic test_stall(input int mode, input int reps);
    for (int r = 0; r < reps; r++) begin
      clr_mon();
      build(2, T);
      do_start();
      send(0, TT, mode);
      repeat (3) @(negedge clk);
      checks++;
      if (count_diff() !== 0) begin
        errors++;
        $display("FAIL stall_m%0d_arrays diffs %0d required 0", mode, count_diff());
      end
      checks++;
      if (pulses !== 1 || pulse_cyc !== last_acc + 1) begin
        errors++;
        $display("FAIL stall_m%0d_pulse got %0d at %0d required 1 at %0d",
                 mode, pulses, pulse_cyc, last_acc + 1);
      end
    end
  endtask

  task automatic test_start_ignored();
    clr_mon();
    build(2, T);
    do_start();
    send(0, 5, 0);
    do_start();
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || s_if.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL start_busy_ctl busy %b ready %b required 1 1", busy, s_if.in_ready);
    end
    send(5, TT - 5, 0);
    repeat (3) @(negedge clk);
    checks++;
    if (count_diff() !== 0 || pulses !== 1) begin
      errors++;
      $display("FAIL start_busy_load diffs %0d pulses %0d required 0 1", count_diff(), pulses);
    end
  endtask

  task automatic test_reset_midload();
    clr_mon();
    build(2, 10);
    do_start();
    send(0, 10, 0);
    repeat (2) @(negedge clk);
    checks++;
    if (count_diff() !== 0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL partial_reload diffs %0d busy %b required 0 1", count_diff(), busy);
    end
    #2 nrst = 1'b0;
    clear_model();
    #1;
    checks++;
    if (count_diff() !== 0 || s_if.in_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_async diffs %0d ready %b busy %b required 0 0 0",
               count_diff(), s_if.in_ready, busy);
    end
    @(negedge clk);
    nrst = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (pulses !== 0 || s_if.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_after pulses %0d ready %b required 0 0", pulses, s_if.in_ready);
    end
  endtask

`ifdef MLP_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    clr_mon();
    build(0, T);
    do_start();
    send(0, TT, 0);
    repeat (3) @(negedge clk);
    checks++;
    if (pulses !== 1 || err !== 1'b0) begin
      errors++;
      $display("FAIL csum_good pulses %0d err %b required 1 0", pulses, err);
    end
    clr_mon();
    build(2, T);
    sq[TT-1] = sq[TT-1] + 8'h01;
    do_start();
    send(0, TT, 0);
    repeat (3) @(negedge clk);
    checks++;
    if (pulses !== 0 || err !== 1'b1 || s_if.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL csum_bad pulses %0d err %b ready %b required 0 1 0",
               pulses, err, s_if.in_ready);
    end
    checks++;
    if (count_diff() !== 0) begin
      errors++;
      $display("FAIL csum_bad_arrays diffs %0d required 0", count_diff());
    end
    build(2, T);
    do_start();
    @(negedge clk);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL csum_clear err %b required 0", err);
    end
    send(0, TT, 0);
    repeat (3) @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_defaults();
    test_index_map();
    test_stall(1, 2);
    test_stall(2, 3);
    test_start_ignored();
    test_reset_midload();
`ifdef MLP_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mlp_param_loader.md
Name: mlp_param_loader

Overview:
Upstream stage of MLP_N_neuron. Accepts a serial valid/ready stream of fixed-point words and unpacks it into the parallel x, w and b arrays.
Once the full set is loaded, it pulses init, initial_flag and weight_flag for one cycle so the MLP starts computing on a consistent parameter set.
This replaces bench-driven parallel loading of the arrays.

Parameters:
M, 3, number of layers; there are M-1 weight/bias layers
N, 3, neurons per layer; also the input vector length
QM, 3, integer bits of the fixed-point word
QN, 5, fractional bits of the fixed-point word

Ports:
clk  input  1  clock
nrst  input  1  asynchronous active-low reset
start  input  1  begin a load sequence (sampled only in IDLE)
in_valid  input  1  in_data valid
in_ready  output  1  loader accepts a word
in_data  input  QM+QN signed  stream word
x  output  [N-1:0] x QM+QN signed  input vector to MLP
w  output  [M-2:0][N-1:0][N-1:0] x QM+QN signed  weights
b  output  [M-2:0][N-1:0] x QM+QN signed  biases
init  output  1  one-cycle start pulse to MLP
initial_flag  output  1  one-cycle pulse, coincident with init
weight_flag  output  1  one-cycle pulse, coincident with init
busy  output  1  high in LOAD (and CHECK when enabled)
err  output  1  sticky checksum error; cleared by next start

Behaviour:
- Reset: asynchronous, active-low. All x/w/b elements are 0; init, initial_flag, weight_flag, busy, in_ready and err are 0; state is IDLE; all counters are 0.
- Clock and reset: single clk domain. Reset is asynchronous and active-low on nrst.
- Transfer: a word is accepted on a rising edge where in_valid && in_ready. The destination element updates on that same edge.
- Stream order, total T = N + (M-1)*N*(N+1) words (27 at defaults):
  - x[0..N-1] first.
  - Then for each layer l = 0..M-2 and each neuron j = 0..N-1: b[l][j], followed by w[l][j][0..N-1].
- Counters: phase (X / LAYER), layer l, neuron j, slot s (s=0 is bias, s=1..N is weight w[l][j][s-1]).
  - Counters advance only on accepted words.
  - s wraps N→0 and increments j; j wraps N-1→0 and increments l.
- FSM:
  - IDLE: in_ready=0. start=1 → LOAD; counters cleared; err cleared.
  - LOAD: in_ready=1, busy=1. Accepting the final word → FIRE (→ CHECK when the feature is enabled).
  - FIRE: lasts exactly one cycle. init, initial_flag and weight_flag are all 1; in_ready=0, busy=0. Then → IDLE.
- Latency: the flags are high in the cycle immediately after the edge that accepts the last word.
- Flags are registered outputs and are 0 in every state other than FIRE.
- start while busy or in FIRE: ignored.
- in_valid=0 stalls: the loader holds all counters, with no timeout.
- Array contents persist after FIRE until overwritten by the next load. Elements not yet rewritten keep their old values during a reload.
- nrst asserted mid-load: the sequence is abandoned and everything returns to reset values. No flags pulse.
- Words are stored verbatim; no saturation or rescaling is applied.

Optional Feature:
MLP_LOADER_CHECKSUM_EN
- Defined:
  - After the last parameter word, the loader enters CHECK with in_ready=1 and waits for one extra word.
  - That word must equal the modulo-2^(QM+QN) sum of all T words.
  - Match → FIRE.
  - Mismatch → err=1, no flags pulse, → IDLE. Array contents remain as loaded.
  - The running sum resets on start and on nrst.
- Undefined: no CHECK state or accumulator; the last word goes directly to FIRE; err is tied 0.

Test Plan:
- Defaults: nrst low 20 ns, then start pulse, then 27 words of 8'h10 (0.5) back-to-back → in_ready high for 27 cycles; one cycle later init, initial_flag and weight_flag are all 1 for exactly one cycle; every x/w/b element = 8'h10.
- Index mapping: stream word k = k for k = 0..26 → x[2]=2, b[0][0]=3, w[0][2][2]=14, b[1][0]=15, w[1][2][2]=26.
- Backpressure: in_valid toggles 1/0 each cycle with the same 27 words → identical array contents; flag pulse occurs one cycle after the 27th accept; no extra pulses.
- Reset mid-load: nrst pulsed low after 10 accepted words → all outputs 0 immediately (asynchronous); no flag pulse; in_ready=0 until the next start.
- start asserted during LOAD after 5 words → counters unchanged; load completes normally after 22 more words.
- With MLP_LOADER_CHECKSUM_EN: 27×8'h10 then 8'hB0 → flags pulse, err=0. Same stream with 8'hB1 → err=1, no flag pulse. A following start clears err.
